// File: rtl/display_pkg.sv
// Shared constants and state encoding for the text console and its display buffer.
package display_pkg;

    localparam int COLS_DEFAULT = 80;
    localparam int ROWS_DEFAULT = 30;

    localparam logic [7:0] CHAR_SPACE = 8'h20;
    localparam logic [7:0] CHAR_LF    = 8'h0A;
    localparam logic [7:0] CHAR_CR    = 8'h0D;
    localparam logic [7:0] CHAR_BS    = 8'h08;
    localparam logic [7:0] CHAR_FF    = 8'h0C;

    typedef enum logic [1:0] {
        CLEAR_ALL  = 2'd0,
        CLEAR_LINE = 2'd1,
        IDLE       = 2'd2
    } state_e;

    function automatic logic is_printable(input logic [7:0] c);
        return (c >= 8'h20) && (c <= 8'h7E);
    endfunction

endpackage

// File: rtl/text_console_if.sv
// Byte stream from the CPU and buffer-write/cursor signals toward the display.
interface text_console_if;

    logic        char_valid;
    logic [7:0]  char_in;
    logic        char_ready;
    logic        buffer_write_enable;
    logic [11:0] position;
    logic [6:0]  char_code;
    logic [4:0]  cursor_row;
    logic [6:0]  cursor_col;
    logic        busy;

    modport master (
        output char_valid, char_in,
        input  char_ready, buffer_write_enable, position, char_code,
               cursor_row, cursor_col, busy
    );

    modport slave (
        input  char_valid, char_in,
        output char_ready, buffer_write_enable, position, char_code,
               cursor_row, cursor_col, busy
    );

endinterface

// File: rtl/text_console.sv
// Character terminal front end: interprets a byte stream and issues text-buffer
// writes, clearing a full screen or a single line one cell per cycle.
module text_console
    import display_pkg::*;
#(
    parameter int COLS = COLS_DEFAULT,
    parameter int ROWS = ROWS_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        char_valid,
    input  logic [7:0]  char_in,
    output logic        char_ready,
    output logic        buffer_write_enable,
    output logic [11:0] position,
    output logic [6:0]  char_code,
    output logic [4:0]  cursor_row,
    output logic [6:0]  cursor_col,
    output logic        busy
);

    localparam logic [11:0] COLS_W    = 12'(COLS);
    localparam logic [11:0] LAST_BASE = 12'((ROWS - 1) * COLS);
    localparam logic [11:0] LAST_CELL = 12'(COLS * ROWS - 1);
    localparam logic [6:0]  LAST_COL  = 7'(COLS - 1);
    localparam logic [4:0]  LAST_ROW  = 5'(ROWS - 1);
    localparam logic [6:0]  SPACE7    = CHAR_SPACE[6:0];

    state_e      state_q, state_d;
    logic [4:0]  row_q, row_d;
    logic [6:0]  col_q, col_d;
    logic [11:0] base_q, base_d;
    logic [11:0] clr_q, clr_d;
    logic        we_q, we_d;
    logic [11:0] pos_q, pos_d;
    logic [6:0]  code_q, code_d;

    logic [4:0]  next_row;
    logic [11:0] next_base;
    logic [11:0] cur_cell;

    // Row base advances by COLS instead of multiplying row by COLS.
    assign next_row  = (row_q == LAST_ROW) ? 5'd0 : row_q + 5'd1;
    assign next_base = (base_q == LAST_BASE) ? 12'd0 : base_q + COLS_W;
    assign cur_cell  = base_q + {5'd0, col_q};

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        base_d  = base_q;
        clr_d   = clr_q;
        we_d    = 1'b0;
        pos_d   = pos_q;
        code_d  = code_q;
        case (state_q)
            CLEAR_ALL: begin
                we_d   = 1'b1;
                pos_d  = clr_q;
                code_d = SPACE7;
                if (clr_q == LAST_CELL) begin
                    clr_d   = 12'd0;
                    state_d = IDLE;
                end else begin
                    clr_d = clr_q + 12'd1;
                end
            end
            CLEAR_LINE: begin
                we_d   = 1'b1;
                pos_d  = clr_q;
                code_d = SPACE7;
                if (clr_q == base_q + COLS_W - 12'd1) begin
                    state_d = IDLE;
                end else begin
                    clr_d = clr_q + 12'd1;
                end
            end
            IDLE: begin
                if (char_valid) begin
                    if (is_printable(char_in)) begin
                        we_d   = 1'b1;
                        pos_d  = cur_cell;
                        code_d = char_in[6:0];
                        if (col_q == LAST_COL) begin
                            col_d   = 7'd0;
                            row_d   = next_row;
                            base_d  = next_base;
                            clr_d   = next_base;
                            state_d = CLEAR_LINE;
                        end else begin
                            col_d = col_q + 7'd1;
                        end
                    end else begin
                        case (char_in)
                            CHAR_LF: begin
                                col_d   = 7'd0;
                                row_d   = next_row;
                                base_d  = next_base;
                                clr_d   = next_base;
                                state_d = CLEAR_LINE;
                            end
                            CHAR_CR: col_d = 7'd0;
                            CHAR_BS: begin
                                if (col_q != 7'd0) begin
                                    col_d  = col_q - 7'd1;
                                    we_d   = 1'b1;
                                    pos_d  = cur_cell - 12'd1;
                                    code_d = SPACE7;
                                end
                            end
                            CHAR_FF: begin
                                row_d   = 5'd0;
                                col_d   = 7'd0;
                                base_d  = 12'd0;
                                clr_d   = 12'd0;
                                state_d = CLEAR_ALL;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            default: state_d = CLEAR_ALL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CLEAR_ALL;
            row_q   <= 5'd0;
            col_q   <= 7'd0;
            base_q  <= 12'd0;
            clr_q   <= 12'd0;
            we_q    <= 1'b0;
            pos_q   <= 12'd0;
            code_q  <= 7'd0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            base_q  <= base_d;
            clr_q   <= clr_d;
            we_q    <= we_d;
            pos_q   <= pos_d;
            code_q  <= code_d;
        end
    end

    assign char_ready          = (state_q == IDLE);
    assign busy                = (state_q != IDLE);
    assign buffer_write_enable = we_q;
    assign position            = pos_q;
    assign char_code           = code_q;
    assign cursor_row          = row_q;
    assign cursor_col          = col_q;

endmodule

// File: tb/tb_text_console.sv
// Scoreboard bench for text_console: expected buffer writes are queued as bytes
// are sent and checked by an independent write monitor.
module tb_text_console;
    import display_pkg::*;

    localparam int COLS  = 80;
    localparam int ROWS  = 30;
    localparam int TOTAL = COLS * ROWS;
    localparam int LIMIT = 5000;

    logic clk = 1'b0;
    logic reset = 1'b1;

    text_console_if cif();

    text_console #(.COLS(COLS), .ROWS(ROWS)) dut (
        .clk                 (clk),
        .reset               (reset),
        .char_valid          (cif.char_valid),
        .char_in             (cif.char_in),
        .char_ready          (cif.char_ready),
        .buffer_write_enable (cif.buffer_write_enable),
        .position            (cif.position),
        .char_code           (cif.char_code),
        .cursor_row          (cif.cursor_row),
        .cursor_col          (cif.cursor_col),
        .busy                (cif.busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] pos;
        logic [6:0]  code;
    } wr_t;

    wr_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_wr(input int p, input int c);
        wr_t e;
        e.pos  = 12'(p);
        e.code = 7'(c);
        exp_q.push_back(e);
    endtask

    task automatic push_spaces(input int first, input int count);
        for (int i = 0; i < count; i++) push_wr(first + i, 32'h20);
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!cif.char_ready && n < LIMIT) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!cif.char_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ready_timeout: char_ready still 0 after %0d cycles, expected 1", n);
        end
    endtask

    task automatic send(input logic [7:0] b, input bit expect_wr);
        int n;
        cif.char_in    = b;
        cif.char_valid = 1'b1;
        wait_ready(n);
        @(posedge clk);
        #1;
        cif.char_valid = 1'b0;
        check($sformatf("write_strobe_after_%02h", b), int'(cif.buffer_write_enable), int'(expect_wr));
    endtask

    task automatic check_cursor(input string name, input int r, input int c);
        int n;
        wait_ready(n);
        check({name, "_row"}, int'(cif.cursor_row), r);
        check({name, "_col"}, int'(cif.cursor_col), c);
    endtask

    always @(negedge clk) begin : monitor
        wr_t e;
        if (!reset && cif.buffer_write_enable) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_write: got pos %0d code %02h, expected no write",
                         cif.position, cif.char_code);
            end else begin
                e = exp_q.pop_front();
                if (cif.position != e.pos || cif.char_code != e.code) begin
                    n_bad++;
                    $display("FAIL buffer_write: got pos %0d code %02h, expected pos %0d code %02h",
                             cif.position, cif.char_code, e.pos, e.code);
                end
            end
        end
    end

    initial begin
        int n;
        cif.char_valid = 1'b0;
        cif.char_in    = 8'h00;
        reset          = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", int'(cif.busy), 1);
        check("reset_ready", int'(cif.char_ready), 0);
        check("reset_we", int'(cif.buffer_write_enable), 0);
        check("reset_pos", int'(cif.position), 0);
        check("reset_code", int'(cif.char_code), 0);
        check("reset_row", int'(cif.cursor_row), 0);
        check("reset_col", int'(cif.cursor_col), 0);

        push_spaces(0, TOTAL);
        reset = 1'b0;
        wait_ready(n);
        check("clear_all_cycles", n, TOTAL);

        push_wr(0, 32'h41);  send(8'h41, 1'b1);
        push_wr(1, 32'h42);  send(8'h42, 1'b1);
        check_cursor("after_AB", 0, 2);

        for (int i = 2; i < 79; i++) begin
            push_wr(i, 32'h78);
            send(8'h78, 1'b1);
        end
        check_cursor("at_col79", 0, 79);
        push_wr(79, 32'h5A);
        push_spaces(80, COLS);
        send(8'h5A, 1'b1);
        check_cursor("after_wrap", 1, 0);

        for (int k = 0; k < 28; k++) begin
            push_spaces((2 + k) * COLS, COLS);
            send(CHAR_LF, 1'b0);
        end
        for (int i = 0; i < 5; i++) begin
            push_wr(2320 + i, 32'h61 + i);
            send(8'h61 + 8'(i), 1'b1);
        end
        check_cursor("at_29_5", 29, 5);
        push_spaces(0, COLS);
        send(CHAR_LF, 1'b0);
        check_cursor("lf_wrap", 0, 0);

        for (int k = 1; k <= 3; k++) begin
            push_spaces(k * COLS, COLS);
            send(CHAR_LF, 1'b0);
        end
        send(CHAR_BS, 1'b0);
        check_cursor("bs_col0", 3, 0);
        for (int i = 0; i < 4; i++) begin
            push_wr(240 + i, 32'h30 + i);
            send(8'h30 + 8'(i), 1'b1);
        end
        push_wr(243, 32'h20);
        send(CHAR_BS, 1'b1);
        check_cursor("bs_col4", 3, 3);

        push_spaces(320, COLS);
        send(CHAR_LF, 1'b0);
        repeat (40) @(posedge clk);
        #1;
        check("mid_line_busy", int'(cif.busy), 1);
        reset = 1'b1;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        check("midreset_we", int'(cif.buffer_write_enable), 0);
        check("midreset_pos", int'(cif.position), 0);
        check("midreset_busy", int'(cif.busy), 1);
        check("midreset_row", int'(cif.cursor_row), 0);
        check("midreset_col", int'(cif.cursor_col), 0);

        push_spaces(0, TOTAL);
        push_wr(0, 32'h51);
        cif.char_in    = 8'h51;
        cif.char_valid = 1'b1;
        reset          = 1'b0;
        wait_ready(n);
        check("restart_clear_cycles", n, TOTAL);
        @(posedge clk);
        #1;
        cif.char_valid = 1'b0;
        check("held_byte_write", int'(cif.buffer_write_enable), 1);
        check_cursor("held_byte", 0, 1);

        send(CHAR_CR, 1'b0);
        check_cursor("after_cr", 0, 0);
        send(8'h7F, 1'b0);
        send(8'hC1, 1'b0);
        send(8'h01, 1'b0);
        send(8'h09, 1'b0);
        check_cursor("after_discard", 0, 0);
        push_wr(0, 32'h41);
        send(8'h41, 1'b1);
        check_cursor("before_ff", 0, 1);
        push_spaces(0, TOTAL);
        send(CHAR_FF, 1'b0);
        check_cursor("after_ff", 0, 0);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
